// File: rtl/counter_pkg.sv
// Purpose: shared state encodings, divider width and default divisors for the counter run-control slice.
// Latency: none (declarations only).
// Backpressure: none.
package counter_pkg;

    localparam int DIV_W = 16;

    localparam int unsigned DIV1_DEFAULT = 4;
    localparam int unsigned DIV2_DEFAULT = 16;
    localparam int unsigned DIV3_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Divisors are held as N-1 so the down-counter hits zero on its Nth run cycle;
    // a divisor of 65536 therefore still fits in DIV_W bits.
    function automatic logic [DIV_W-1:0] div_minus_one(input int unsigned n);
        return DIV_W'(n - 1);
    endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Purpose: control/observe bundle between the user controls, the sequencer and the counter datapath.
// Latency: none (wires only).
// Backpressure: none; levels are sampled every cycle by the sequencer.
// Ports: Start/Stop/Mode/RateSel/Limit from the controls, CounterValue from the counter,
//        CounterEnable/CounterClear_b/Busy/Done driven by the sequencer.
interface counter_sequencer_if;
    logic       Start;
    logic       Stop;
    logic       Mode;
    logic [1:0] RateSel;
    logic [7:0] Limit;
    logic [7:0] CounterValue;
    logic       CounterEnable;
    logic       CounterClear_b;
    logic       Busy;
    logic       Done;

    modport master (
        output Start, Stop, Mode, RateSel, Limit, CounterValue,
        input  CounterEnable, CounterClear_b, Busy, Done
    );

    modport slave (
        input  Start, Stop, Mode, RateSel, Limit, CounterValue,
        output CounterEnable, CounterClear_b, Busy, Done
    );
endinterface

// File: rtl/rate_divider.sv
// Purpose: programmable down-counter producing a one-cycle tick every (reload+1) run cycles.
// Latency: first tick reload+1 run cycles after load; tick is combinational from the count.
// Backpressure: none; run low freezes the count in place.
// Ports: Clock, Reset (sync, active-high), load (preset to reload), run (count enable),
//        reload (N-1), tick (count==0 while running).
module rate_divider
    import counter_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] div;

    assign tick = run && (div == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div <= '0;
        end else if (load) begin
            div <= reload;
        end else if (run) begin
            if (div == '0) begin
                div <= reload;
            end else begin
                div <= div - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Purpose: run-control FSM for the 8-bit counter: launch, clear, paced count, pause/resume, terminal detect.
// Latency: Start edge -> CLEAR next cycle -> RUN after; Done registered one cycle after the terminal tick.
// Backpressure: none; Stop pauses a run (aborts from PAUSE), Stop beats Start, terminal tick beats Stop.
// Ports: Clock, Reset (sync, active-high), bus (slave side of counter_sequencer_if).
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int unsigned DIV1 = DIV1_DEFAULT,
    parameter int unsigned DIV2 = DIV2_DEFAULT,
    parameter int unsigned DIV3 = DIV3_DEFAULT
)(
    input  logic                  Clock,
    input  logic                  Reset,
    counter_sequencer_if.slave    bus
);

    seq_state_t       state;
    seq_state_t       state_nx;

    logic [7:0]       limit_q;
    logic             mode_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_sel;

    logic             launch;
    logic             tick;
    logic             terminal;
    logic             done_q;

    // Launch only from a resting state; Stop suppresses a simultaneous Start.
    assign launch = ((state == ST_IDLE) || (state == ST_DONE)) && bus.Start && !bus.Stop;

    always_comb begin
        div_sel = '0;
        case (bus.RateSel)
            2'd1:    div_sel = div_minus_one(DIV1);
            2'd2:    div_sel = div_minus_one(DIV2);
            2'd3:    div_sel = div_minus_one(DIV3);
            default: div_sel = '0;
        endcase
    end

    rate_divider u_rate_divider (
        .Clock  (Clock),
        .Reset  (Reset),
        .load   (state == ST_CLEAR),
        .run    (state == ST_RUN),
        .reload (div_q),
        .tick   (tick)
    );

    // The compare uses the value the counter holds now, so the tick that would
    // step past the limit is the one that ends the run instead.
    assign terminal = tick && (bus.CounterValue == limit_q);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (launch) state_nx = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (terminal) begin
                    state_nx = mode_q ? ST_CLEAR : ST_DONE;
                end else if (bus.Stop) begin
                    state_nx = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.Stop) begin
                    state_nx = ST_IDLE;
                end else if (bus.Start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                if (launch) state_nx = ST_CLEAR;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_IDLE;
            limit_q <= '0;
            mode_q  <= 1'b0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= terminal;
            if (launch) begin
                limit_q <= bus.Limit;
                mode_q  <= bus.Mode;
                div_q   <= div_sel;
            end
        end
    end

    // Enable is gated by Reset so a run interrupted by reset cannot also step the counter.
    assign bus.CounterEnable  = tick && !terminal && !Reset;
    assign bus.CounterClear_b = !(Reset || (state == ST_CLEAR));
    assign bus.Busy           = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_PAUSE);
    assign bus.Done           = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Purpose: self-checking bench for counter_sequencer driving a behavioural 8-bit counter.
// Latency: expected Done cycles derived from launch edge, limit, divisor and pause length.
// Backpressure: none.
module tb_counter_sequencer;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    counter_sequencer_if bus();

    counter_sequencer #(
        .DIV1 (4),
        .DIV2 (16),
        .DIV3 (256)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // Counter datapath: synchronous active-low clear, count on Enable.
    logic [7:0] cnt;
    always @(posedge Clock) begin
        if (bus.CounterClear_b !== 1'b1) cnt <= 8'd0;
        else if (bus.CounterEnable === 1'b1) cnt <= cnt + 8'd1;
    end
    assign bus.CounterValue = cnt;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int cyc;
        int val;
        int ens;
        int busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   en_cnt    = 0;
    int   cur_limit = 0;
    bit   lim_chk   = 1'b0;

    task automatic check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int c, input int v, input int e, input int b);
        exp_t x;
        x.cyc = c; x.val = v; x.ens = e; x.busy = b;
        sb.push_back(x);
    endtask

    task automatic at(input int x);
        while (cyc < x) @(negedge Clock);
    endtask

    function automatic int nval(input int rs);
        case (rs)
            1:       return 4;
            2:       return 16;
            3:       return 256;
            default: return 1;
        endcase
    endfunction

    // Start sampled at the edge that makes cyc == s; launch inputs scrambled afterwards.
    task automatic launch(input int s, input bit md, input int rs, input int lim);
        at(s - 1);
        bus.Start   = 1'b1;
        bus.Mode    = md;
        bus.RateSel = 2'(rs);
        bus.Limit   = 8'(lim);
        at(s);
        bus.Start   = 1'b0;
        cur_limit   = lim;
        bus.Mode    = 1'($urandom_range(0, 1));
        bus.RateSel = 2'($urandom_range(0, 3));
        bus.Limit   = 8'($urandom_range(0, 255));
    endtask

    // Monitor: pops an expectation whenever Done is presented.
    always @(negedge Clock) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_missing: no Done at cycle %0d, now cycle %0d", sb[0].cyc, cyc);
            sb.delete(0);
        end
        if (bus.Done === 1'b1) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                check("done_value", int'(bus.CounterValue), mon_e.val);
                check("done_enables", en_cnt, mon_e.ens);
                check("done_busy", int'(bus.Busy), mon_e.busy);
            end else begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: Done at cycle %0d, next expected %0d",
                         cyc, (sb.size() > 0) ? sb[0].cyc : -1);
            end
        end
        if (bus.CounterClear_b === 1'b0) en_cnt = 0;
        else if (bus.CounterEnable === 1'b1) en_cnt++;
        if (lim_chk && bus.CounterClear_b === 1'b1) begin
            n_chk++;
            if (int'(bus.CounterValue) > cur_limit) begin
                n_fail++;
                $display("FAIL value_le_limit: got %0d, limit %0d (cycle %0d)",
                         bus.CounterValue, cur_limit, cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, last, rs, n, l, md, t, j, p, k, maxl;
        bus.Start   = 1'b0;
        bus.Stop    = 1'b0;
        bus.Mode    = 1'b0;
        bus.RateSel = 2'd0;
        bus.Limit   = 8'd0;
        @(negedge Clock);

        // Reset state
        at(2);
        check("rst_busy", int'(bus.Busy), 0);
        check("rst_done", int'(bus.Done), 0);
        check("rst_enable", int'(bus.CounterEnable), 0);
        check("rst_clear_b", int'(bus.CounterClear_b), 0);
        check("rst_value", int'(bus.CounterValue), 0);
        Reset = 1'b0;
        at(3);
        check("post_rst_clear_b", int'(bus.CounterClear_b), 1);
        lim_chk = 1'b1;

        // One-shot, N=1, Limit=3
        s = cyc + 2;
        push(s + 5, 3, 3, 0);
        launch(s, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            at(s + 1 + i);
            check("oneshot_seq", int'(bus.CounterValue), i);
        end
        at(s + 7);
        check("oneshot_busy_after", int'(bus.Busy), 0);
        check("oneshot_hold", int'(bus.CounterValue), 3);

        // Auto-reload, N=4, Limit=2: period 13
        s = cyc + 2;
        for (int i = 0; i < 3; i++) push(s + 13 + i * 13, 2, 2, 1);
        last = s + 39;
        launch(s, 1, 1, 2);
        at(s + 4);
        check("auto_seq_hold", int'(bus.CounterValue), 0);
        at(s + 5);
        check("auto_seq_step", int'(bus.CounterValue), 1);
        at(last + 1);
        bus.Stop = 1'b1;
        at(last + 3);
        bus.Stop = 1'b0;
        check("auto_abort_busy", int'(bus.Busy), 0);

        // Start and Stop together in IDLE: no launch
        s = cyc + 2;
        at(s - 1);
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        at(s);
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        check("idle_startstop_busy", int'(bus.Busy), 0);

        // Pause for 7 cycles at value 2, N=1, Limit=5
        s = cyc + 2;
        push(s + 14, 5, 5, 0);
        launch(s, 0, 0, 5);
        at(s + 2);
        bus.Stop = 1'b1;
        at(s + 3);
        bus.Stop = 1'b0;
        check("pause_value", int'(bus.CounterValue), 2);
        check("pause_busy", int'(bus.Busy), 1);
        at(s + 9);
        check("pause_frozen", int'(bus.CounterValue), 2);
        bus.Start = 1'b1;
        at(s + 10);
        bus.Start = 1'b0;
        at(s + 15);

        // Start and Stop together in RUN -> PAUSE; then together in DONE -> nothing
        s = cyc + 2;
        push(s + 16, 10, 10, 0);
        launch(s, 0, 0, 10);
        at(s + 3);
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        at(s + 4);
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        check("run_startstop_value", int'(bus.CounterValue), 3);
        check("run_startstop_busy", int'(bus.Busy), 1);
        at(s + 6);
        check("run_startstop_frozen", int'(bus.CounterValue), 3);
        at(s + 7);
        bus.Start = 1'b1;
        at(s + 8);
        bus.Start = 1'b0;
        at(s + 17);
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        at(s + 18);
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        check("done_startstop_busy", int'(bus.Busy), 0);
        at(s + 19);
        check("done_startstop_hold", int'(bus.CounterValue), 10);

        // Limit=0: no increments, Done two cycles after the Start edge
        s = cyc + 2;
        push(s + 2, 0, 0, 0);
        launch(s, 0, 0, 0);
        at(s + 3);

        // Limit=255: reaches 255 and holds, no wrap
        s = cyc + 2;
        push(s + 257, 255, 255, 0);
        launch(s, 0, 0, 255);
        at(s + 259);
        check("lim255_hold", int'(bus.CounterValue), 255);

        // Reset mid-run at value 4
        s = cyc + 2;
        launch(s, 0, 0, 10);
        at(s + 5);
        check("midrst_value_before", int'(bus.CounterValue), 4);
        Reset = 1'b1;
        #1;
        check("midrst_clear_b", int'(bus.CounterClear_b), 0);
        check("midrst_enable", int'(bus.CounterEnable), 0);
        at(s + 6);
        Reset = 1'b0;
        check("midrst_value_after", int'(bus.CounterValue), 0);
        check("midrst_busy", int'(bus.Busy), 0);
        check("midrst_done", int'(bus.Done), 0);
        s = cyc + 2;
        push(s + 13, 2, 2, 0);
        launch(s, 0, 1, 2);
        at(s + 14);

        // Randomized runs
        for (int it = 0; it < 16; it++) begin
            rs   = $urandom_range(0, 3);
            n    = nval(rs);
            maxl = 300 / n - 1;
            if (maxl > 255) maxl = 255;
            l  = $urandom_range(0, maxl);
            md = $urandom_range(0, 1);
            t  = (l + 1) * n;
            if (md == 1 && t < 2) begin
                l = 1;
                t = 2 * n;
            end
            s = cyc + 2 + $urandom_range(0, 3);
            if (md == 0) begin
                p = 0;
                j = 0;
                if (t >= 2 && $urandom_range(0, 1) == 1) begin
                    j = $urandom_range(0, t - 2);
                    p = $urandom_range(1, 6);
                end
                push(s + 1 + t + p, l, l, 0);
                launch(s, 0, rs, l);
                if (p > 0) begin
                    at(s + 1 + j);
                    bus.Stop = 1'b1;
                    at(s + 2 + j);
                    bus.Stop = 1'b0;
                    at(s + 1 + j + p);
                    bus.Start = 1'b1;
                    at(s + 2 + j + p);
                    bus.Start = 1'b0;
                end
                at(s + 2 + t + p);
            end else begin
                k = $urandom_range(1, 3);
                for (int i = 0; i < k; i++) push(s + 1 + t + i * (t + 1), l, l, 1);
                last = s + 1 + t + (k - 1) * (t + 1);
                launch(s, 1, rs, l);
                at(last + 1);
                bus.Stop = 1'b1;
                at(last + 3);
                bus.Stop = 1'b0;
                check("rand_abort_busy", int'(bus.Busy), 0);
            end
        end

        at(cyc + 5);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
